mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1: 1 = alternate on tie; 0 = data port always wins on tie.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 i_req_i  input  1  instruction-fetch read request; held until i_ack_o.
REQ-005 i_addr_i  input  32  fetch byte address; held with i_req_i.
REQ-006 i_data_o  output  32  fetched word; registered.
REQ-007 i_ack_o  output  1  one-cycle fetch completion pulse.
REQ-008 d_rd_en_i  input  1  data read request; held until d_ack_o.
REQ-009 d_wr_en_i  input  1  data write request; held until d_ack_o.
REQ-010 d_addr_i  input  32  data byte address.
REQ-011 d_data_i  input  32  write data.
REQ-012 d_data_o  output  32  read word; registered.
REQ-013 d_ack_o  output  1  one-cycle data completion pulse.
REQ-014 mem_rd_en_o, mem_wr_en_o  output  1 each  memory strobes.
REQ-015 mem_addr_o  output  32  memory address.
REQ-016 mem_data_o  output  32  memory write data.
REQ-017 mem_data_i  input  32  memory read data (combinational from memory).
REQ-018 mem_ack_i  input  1  memory ready; access completes in any cycle it is high.

Function
REQ-019 FSM states IDLE, SERV_I, SERV_D, RESP; encoding is free.
REQ-020 IDLE: i_req_i only -> SERV_I; d request (d_rd_en_i or d_wr_en_i) only -> SERV_D; none -> stay IDLE.
REQ-021 IDLE, both requesting: ROUND_ROBIN=1 grants port not granted last (last_grant register); ROUND_ROBIN=0 grants D.
REQ-022 On leaving IDLE, address, write data and read/write kind of granted port are captured into internal registers; memory is driven only from captured values.
REQ-023 d_wr_en_i and d_rd_en_i both high: treated as write.
REQ-024 SERV_I: mem_rd_en_o=1, mem_wr_en_o=0, mem_addr_o=captured address, mem_data_o=0.
REQ-025 SERV_D read: mem_rd_en_o=1, mem_wr_en_o=0; SERV_D write: mem_rd_en_o=0, mem_wr_en_o=1, mem_data_o=captured data.
REQ-026 IDLE and RESP: all mem_* outputs 0.
REQ-027 SERV_x with mem_ack_i=1: read loads mem_data_i into i_data_o or d_data_o; next state RESP; last_grant updated to x.
REQ-028 SERV_x with mem_ack_i=0: stay SERV_x, hold memory outputs unchanged; repeated identical writes acceptable.
REQ-029 RESP: assert ack of served port for exactly one cycle; other ack 0; next state IDLE unconditionally.
REQ-030 Requester deasserts request on the edge ending its ack cycle; IDLE re-evaluates fresh in the following cycle.
REQ-031 Latency with mem_ack_i=1: request seen in IDLE at cycle N -> memory driven N+1 -> ack and data valid N+2; back-to-back throughput one access per 3 cycles.
REQ-032 Write completion leaves d_data_o unchanged; i_data_o/d_data_o otherwise hold value between accesses.
REQ-033 Requests arriving while not IDLE are not sampled until IDLE; never lost if held.

Reset
REQ-034 rst=1 immediately forces IDLE; all outputs 0, i_data_o=d_data_o=0, last_grant=D (first tie goes to I when ROUND_ROBIN=1).
REQ-035 Reset during SERV_x or RESP cancels the access: mem_wr_en_o drops asynchronously, no ack issued for it.
REQ-036 After rst deasserts, first evaluation occurs in IDLE on the next rising edge.

Verification
REQ-037 I fetch 0x0000_0010, memory word 0x00A0_0093, mem_ack_i=1 -> mem_rd_en_o high one cycle at addr 0x10; i_ack_o pulse 2 cycles after request; i_data_o=0x00A0_0093.
REQ-038 D write 0x0000_0020 data 0xDEAD_BEEF, then D read 0x20 -> mem_wr_en_o one cycle; d_ack_o pulse; read returns 0xDEAD_BEEF; d_data_o unchanged after the write ack.
REQ-039 I and D request same cycle, held continuously, ROUND_ROBIN=1, after reset -> grant order I, D, I, D; acks 3 cycles apart; ROUND_ROBIN=0 -> D served first.
REQ-040 mem_ack_i held low 4 cycles during SERV_D read -> mem_* outputs stable 5 cycles; d_ack_o one cycle after mem_ack_i rises.
REQ-041 rst asserted mid SERV_D write -> mem_wr_en_o 0 same cycle; no d_ack_o; after release pending held request re-granted from IDLE.
REQ-042 d_rd_en_i and d_wr_en_i both high -> write performed, mem_rd_en_o stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port (I, read only) and a data port (D, read/write).
//
// Handshake: each requester raises its request (i_req_i, or d_rd_en_i /
// d_wr_en_i) together with address/data and holds all of them until it sees
// its one-cycle ack. The ack and read data come from registers. Memory
// strobes stay asserted, with stable address/data, until mem_ack_i is
// sampled high on a rising edge.
//
// Flow: IDLE -> SERV_I or SERV_D (memory driven from captured values)
//   -> RESP (one-cycle ack) -> IDLE. A back-to-back stream therefore takes
// three cycles per access.
// Tie-break: with ROUND_ROBIN != 0 the port not served last wins. Otherwise
// D always wins.
// dbg_state exposes the FSM encoding for external checkers.
module mem_arbiter #(
   parameter int ROUND_ROBIN = 1
) (
   input  logic        clk,
   input  logic        rst,
   // instruction-fetch port
   input  logic        i_req_i,
   input  logic [31:0] i_addr_i,
   output logic [31:0] i_data_o,
   output logic        i_ack_o,
   // data port
   input  logic        d_rd_en_i,
   input  logic        d_wr_en_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_data_i,
   output logic [31:0] d_data_o,
   output logic        d_ack_o,
   // memory side
   output logic        mem_rd_en_o,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i,
   // FSM state for checkers
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERV_I = 2'd1,
      SERV_D = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        d_req;
   logic        any_req;
   logic        grant_d;
   logic        last_grant_d;   // 1 = D was served last
   logic        cap_d;          // captured port: 1 = D, 0 = I
   logic        cap_wr;         // captured access kind: 1 = write
   logic [31:0] cap_addr;
   logic [31:0] cap_data;

   assign d_req     = d_rd_en_i | d_wr_en_i;
   assign any_req   = i_req_i | d_req;
   assign dbg_state = state;

   // Arbitration decision used in IDLE: which port gets the memory next
   always_comb begin
      grant_d = 1'b0;
      if (d_req && !i_req_i) begin
         grant_d = 1'b1;
      end else if (d_req && i_req_i) begin
         if (ROUND_ROBIN != 0) begin
            grant_d = ~last_grant_d;
         end else begin
            grant_d = 1'b1;
         end
      end
   end

   // State register; reset drops straight to IDLE, cancelling any access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = grant_d ? SERV_D : SERV_I;
            end
         end
         SERV_I, SERV_D: begin
            if (mem_ack_i) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Capture the granted request on leaving IDLE and register read data on completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_d        <= 1'b0;
         cap_wr       <= 1'b0;
         cap_addr     <= 32'h0;
         cap_data     <= 32'h0;
         last_grant_d <= 1'b1;
         i_data_o     <= 32'h0;
         d_data_o     <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  cap_d    <= grant_d;
                  // simultaneous read+write on D is a write
                  cap_wr   <= grant_d & d_wr_en_i;
                  cap_addr <= grant_d ? d_addr_i : i_addr_i;
                  cap_data <= grant_d ? d_data_i : 32'h0;
               end
            end
            SERV_I: begin
               if (mem_ack_i) begin
                  i_data_o     <= mem_data_i;
                  last_grant_d <= 1'b0;
               end
            end
            SERV_D: begin
               if (mem_ack_i) begin
                  if (!cap_wr) begin
                     d_data_o <= mem_data_i;
                  end
                  last_grant_d <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decoded from state and captured request only
   always_comb begin
      mem_rd_en_o = 1'b0;
      mem_wr_en_o = 1'b0;
      mem_addr_o  = 32'h0;
      mem_data_o  = 32'h0;
      i_ack_o     = 1'b0;
      d_ack_o     = 1'b0;
      case (state)
         SERV_I: begin
            mem_rd_en_o = 1'b1;
            mem_addr_o  = cap_addr;
         end
         SERV_D: begin
            mem_rd_en_o = ~cap_wr;
            mem_wr_en_o = cap_wr;
            mem_addr_o  = cap_addr;
            mem_data_o  = cap_wr ? cap_data : 32'h0;
         end
         RESP: begin
            i_ack_o = ~cap_d;
            d_ack_o = cap_d;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed accesses against a small word memory
// model. Expected acks (port + data) are queued by the driver and checked
// by an independent monitor. A second instance with ROUND_ROBIN=0 covers
// the fixed-priority tie.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_data_o;
   logic        i_ack_o;
   logic        d_rd;
   logic        d_wr;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_data_o;
   logic        d_ack_o;
   logic        mem_rd_en_o;
   logic        mem_wr_en_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;
   logic        mem_ack_i;
   logic        mem_ack_en;
   logic [1:0]  dbg_state;

   // fixed-priority instance: memory always ready, constant read word
   logic        r0_i_req;
   logic        r0_d_rd;
   logic [31:0] r0_i_data;
   logic        r0_i_ack;
   logic [31:0] r0_d_data;
   logic        r0_d_ack;
   logic        r0_mem_rd;
   logic        r0_mem_wr;
   logic [31:0] r0_mem_addr;
   logic [31:0] r0_mem_wdata;
   logic [1:0]  r0_dbg_state;

   logic [31:0] mem_model [0:255];
   logic [32:0] exp_q [$];   // {is_d, expected data register value}
   int          checks;
   int          errors;
   int          wr_cycles;
   int          rd_cycles;

   mem_arbiter #(.ROUND_ROBIN(1)) dut (
      .clk(clk), .rst(rst),
      .i_req_i(i_req), .i_addr_i(i_addr), .i_data_o(i_data_o), .i_ack_o(i_ack_o),
      .d_rd_en_i(d_rd), .d_wr_en_i(d_wr), .d_addr_i(d_addr), .d_data_i(d_wdata),
      .d_data_o(d_data_o), .d_ack_o(d_ack_o),
      .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .dbg_state(dbg_state)
   );

   mem_arbiter #(.ROUND_ROBIN(0)) dut_rr0 (
      .clk(clk), .rst(rst),
      .i_req_i(r0_i_req), .i_addr_i(32'h0000_0004), .i_data_o(r0_i_data), .i_ack_o(r0_i_ack),
      .d_rd_en_i(r0_d_rd), .d_wr_en_i(1'b0), .d_addr_i(32'h0000_0008), .d_data_i(32'h0),
      .d_data_o(r0_d_data), .d_ack_o(r0_d_ack),
      .mem_rd_en_o(r0_mem_rd), .mem_wr_en_o(r0_mem_wr),
      .mem_addr_o(r0_mem_addr), .mem_data_o(r0_mem_wdata),
      .mem_data_i(32'h1234_5678), .mem_ack_i(1'b1),
      .dbg_state(r0_dbg_state)
   );

   assign mem_data_i = mem_model[mem_addr_o[9:2]];
   assign mem_ack_i  = mem_ack_en;

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   // memory model: preload, then write on any acknowledged write strobe
   initial begin
      for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
      mem_model[4] = 32'h00A0_0093;
      forever begin
         @(posedge clk);
         if (mem_wr_en_o && mem_ack_i) mem_model[mem_addr_o[9:2]] = mem_data_o;
      end
   end

   // strobe activity counters sampled mid-cycle
   initial begin
      wr_cycles = 0;
      rd_cycles = 0;
      forever begin
         @(negedge clk);
         if (mem_wr_en_o) wr_cycles++;
         if (mem_rd_en_o) rd_cycles++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard monitor: every ack pops one expected entry
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (!rst && (i_ack_o || d_ack_o)) begin
            chk("sb_one_ack", 32'(i_ack_o & d_ack_o), 32'h0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_ack: got i_ack=%0b d_ack=%0b expected no ack", i_ack_o, d_ack_o);
            end else begin
               e = exp_q.pop_front();
               chk("sb_port", 32'(d_ack_o), 32'(e[32]));
               chk("sb_data", d_ack_o ? d_data_o : i_data_o, e[31:0]);
            end
         end
      end
   end

   // driver: wait (bounded) for the ack of one port
   task automatic wait_ack(input bit is_d, input int budget);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         @(negedge clk);
         if (is_d ? d_ack_o : i_ack_o) ok = 1'b1;
      end
      chk(is_d ? "d_ack_timeout" : "i_ack_timeout", 32'(ok), 32'h1);
   endtask

   // driver: one complete data-port access, request dropped after its ack
   task automatic d_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data);
      exp_q.push_back({1'b1, exp_data});
      d_rd    = rd;
      d_wr    = wr;
      d_addr  = addr;
      d_wdata = wdata;
      wait_ack(1'b1, 10);
      @(posedge clk); #1;
      d_rd = 1'b0;
      d_wr = 1'b0;
   endtask

   initial begin
      int w0;
      int r0;
      int waited;
      bit found;
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      i_req      = 1'b0;
      i_addr     = 32'h0;
      d_rd       = 1'b0;
      d_wr       = 1'b0;
      d_addr     = 32'h0;
      d_wdata    = 32'h0;
      mem_ack_en = 1'b1;
      r0_i_req   = 1'b0;
      r0_d_rd    = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_strobes_acks", 32'({i_ack_o, d_ack_o, mem_rd_en_o, mem_wr_en_o}), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'h0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_i_data", i_data_o, 32'h0);
      chk("rst_d_data", d_data_o, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // instruction fetch, memory ready: strobe in N+1, ack in N+2
      exp_q.push_back({1'b0, 32'h00A0_0093});
      i_req  = 1'b1;
      i_addr = 32'h0000_0010;
      @(negedge clk);
      chk("fetch_idle_rd", 32'(mem_rd_en_o), 32'h0);
      @(negedge clk);
      chk("fetch_rd", 32'({mem_rd_en_o, mem_wr_en_o}), 32'h2);
      chk("fetch_addr", mem_addr_o, 32'h0000_0010);
      chk("fetch_wdata", mem_data_o, 32'h0);
      @(negedge clk);
      chk("fetch_ack", 32'(i_ack_o), 32'h1);
      chk("fetch_rd_off", 32'(mem_rd_en_o), 32'h0);
      @(posedge clk); #1;
      i_req = 1'b0;
      @(negedge clk);
      chk("fetch_ack_pulse", 32'(i_ack_o), 32'h0);
      chk("fetch_data_hold", i_data_o, 32'h00A0_0093);
      @(posedge clk); #1;

      // data write then read back; write leaves d_data_o alone
      w0 = wr_cycles;
      d_access(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0);
      chk("wr_strobe_cycles", 32'(wr_cycles - w0), 32'h1);
      chk("wr_mem_word", mem_model[8], 32'hDEAD_BEEF);
      chk("wr_keeps_d_data", d_data_o, 32'h0);
      d_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF);
      chk("rd_d_data", d_data_o, 32'hDEAD_BEEF);
      chk("rd_i_data_hold", i_data_o, 32'h00A0_0093);

      // tie after reset, round robin: I, D, I, D, acks 3 cycles apart
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.push_back({1'b0, 32'h00A0_0093});
      exp_q.push_back({1'b1, 32'hDEAD_BEEF});
      exp_q.push_back({1'b0, 32'h00A0_0093});
      exp_q.push_back({1'b1, 32'hDEAD_BEEF});
      i_req  = 1'b1;
      i_addr = 32'h0000_0010;
      d_rd   = 1'b1;
      d_addr = 32'h0000_0020;
      for (int k = 0; k < 4; k++) begin
         waited = 0;
         found  = 1'b0;
         while (waited < 8 && !found) begin
            @(negedge clk);
            waited++;
            if (i_ack_o || d_ack_o) found = 1'b1;
         end
         chk("tie_ack_seen", 32'(found), 32'h1);
         chk("tie_port", 32'(d_ack_o), 32'(k % 2));
         chk("tie_gap", 32'(waited), 32'h3);
      end
      @(posedge clk); #1;
      i_req = 1'b0;
      d_rd  = 1'b0;

      // fixed priority instance: D wins the tie
      r0_i_req = 1'b1;
      r0_d_rd  = 1'b1;
      found    = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         @(negedge clk);
         if (r0_i_ack || r0_d_ack) found = 1'b1;
      end
      chk("rr0_ack_seen", 32'(found), 32'h1);
      chk("rr0_first_is_d", 32'({r0_d_ack, r0_i_ack}), 32'h2);
      chk("rr0_d_data", r0_d_data, 32'h1234_5678);
      @(posedge clk); #1;
      r0_i_req = 1'b0;
      r0_d_rd  = 1'b0;

      // memory stalls four cycles during a data read
      @(posedge clk); #1;
      mem_ack_en = 1'b0;
      exp_q.push_back({1'b1, 32'h00A0_0093});
      d_rd   = 1'b1;
      d_addr = 32'h0000_0010;
      found  = 1'b0;
      for (int k = 0; k < 5 && !found; k++) begin
         @(negedge clk);
         if (mem_rd_en_o) found = 1'b1;
      end
      chk("stall_start", 32'(found), 32'h1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_hold_strobes", 32'({mem_rd_en_o, mem_wr_en_o}), 32'h2);
         chk("stall_hold_addr", mem_addr_o, 32'h0000_0010);
         chk("stall_no_ack", 32'(d_ack_o), 32'h0);
      end
      @(posedge clk); #1;
      mem_ack_en = 1'b1;
      @(negedge clk);
      chk("stall_last_strobes", 32'({mem_rd_en_o, mem_wr_en_o}), 32'h2);
      chk("stall_last_addr", mem_addr_o, 32'h0000_0010);
      @(negedge clk);
      chk("stall_ack", 32'(d_ack_o), 32'h1);
      @(posedge clk); #1;
      d_rd = 1'b0;

      // reset in the middle of a stalled write: cancelled, then re-granted
      mem_ack_en = 1'b0;
      exp_q.push_back({1'b1, 32'h0});
      d_wr    = 1'b1;
      d_addr  = 32'h0000_0030;
      d_wdata = 32'h55AA_1234;
      found   = 1'b0;
      for (int k = 0; k < 5 && !found; k++) begin
         @(negedge clk);
         if (mem_wr_en_o) found = 1'b1;
      end
      chk("cancel_wr_seen", 32'(found), 32'h1);
      rst = 1'b1;
      #1;
      chk("cancel_wr_drop", 32'(mem_wr_en_o), 32'h0);
      chk("cancel_state", 32'(dbg_state), 32'h0);
      mem_ack_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("regrant_idle", 32'(dbg_state), 32'h0);
      wait_ack(1'b1, 10);
      @(posedge clk); #1;
      d_wr = 1'b0;
      chk("regrant_mem_word", mem_model[12], 32'h55AA_1234);

      // read and write both high: performed as a write
      r0 = rd_cycles;
      w0 = wr_cycles;
      d_access(1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_0001, 32'h0);
      chk("both_no_rd", 32'(rd_cycles - r0), 32'h0);
      chk("both_one_wr", 32'(wr_cycles - w0), 32'h1);
      chk("both_mem_word", mem_model[16], 32'hCAFE_0001);

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
